ysyx_22050612_ifu: RTL and testbench
====================================

YSYX_22050612_IFU -- requirements
Module: ysyx_22050612_IFU

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 mem_req_valid  output  1  SHALL flag an instruction fetch request.
REQ-005 mem_req_addr  output  64  SHALL carry the fetch address (current PC).
REQ-006 mem_req_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-007 mem_rsp_valid  input  1  SHALL flag a returned instruction word.
REQ-008 mem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-009 redirect_valid  input  1  SHALL request a PC change (branch/jump taken).
REQ-010 redirect_pc  input  64  SHALL carry the redirect target.
REQ-011 inst  output  32  SHALL carry the fetched instruction to the decoder.
REQ-012 inst_pc  output  64  SHALL carry the PC of inst.
REQ-013 inst_valid  output  1  SHALL flag inst/inst_pc as valid.
REQ-014 inst_ready  input  1  SHALL indicate the decoder consumes inst this cycle.
REQ-015 halted  output  1  SHALL flag ebreak halt (tied 0 without the macro).

Function
REQ-016 States: IDLE, REQ, WAIT, HOLD, HALT; one outstanding fetch maximum.
REQ-017 IDLE SHALL go to REQ on the first clock after reset release.
REQ-018 REQ: mem_req_valid = ~redirect_valid, mem_req_addr = pc; on mem_req_valid & mem_req_ready -> WAIT.
REQ-019 REQ with redirect_valid: pc <= redirect_pc, stay in REQ, no request issued that cycle.
REQ-020 WAIT: mem_rsp_valid with no pending drop -> capture mem_rsp_data into inst, pc into inst_pc, -> HOLD.
REQ-021 WAIT with redirect_valid: set drop flag, store redirect_pc as next pc; a later redirect overwrites the stored target.
REQ-022 WAIT with mem_rsp_valid and drop flag set (or redirect in the same cycle): discard data, clear drop, pc <= stored/new target, -> REQ.
REQ-023 HOLD: inst_valid = 1; inst/inst_pc SHALL stay stable until consumed.
REQ-024 HOLD with inst_ready and no redirect: pc <= pc + 4 (64-bit, wraps modulo 2^64), -> REQ.
REQ-025 HOLD with redirect_valid: redirect wins over inst_ready; inst dropped (inst_valid low next cycle), pc <= redirect_pc, -> REQ.
REQ-026 inst_valid SHALL be 1 only in HOLD; mem_rsp_valid outside WAIT SHALL be ignored.
REQ-027 Minimum latency: request accept to inst_valid = 1 cycle after mem_rsp_valid; back-to-back throughput one instruction per 3 cycles with zero-latency memory.

Reset
REQ-028 rst SHALL immediately force: state IDLE, pc = RESET_PC, drop = 0, inst = 0, inst_pc = 0, inst_valid = 0, mem_req_valid = 0, halted = 0.
REQ-029 rst during WAIT SHALL abandon the outstanding fetch; the late response SHALL be ignored.

Configuration
REQ-030 Macro YSYX_22050612_IFU_EBREAK_HALT_EN defined: when an instruction equal to 32'h00100073 is consumed in HOLD (no redirect), -> HALT; halted = 1, no further requests; leave only by reset.
REQ-031 Macro undefined: ebreak treated as ordinary instruction, HALT unreachable, halted tied 0.

Verification
REQ-032 Reset release, mem_req_ready=1, response 1 cycle later with 32'h00000013 -> mem_req_addr 0x80000000, inst=0x00000013, inst_pc=0x80000000, next addr 0x80000004.
REQ-033 inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new mem_req_valid; ready 1 -> next request at pc+4.
REQ-034 redirect_valid to 0x80000100 during WAIT, response 32'hDEADBEEF -> data dropped, inst_valid stays 0, next request address 0x80000100.
REQ-035 redirect_valid to 0x80000200 and inst_ready same cycle in HOLD -> next request 0x80000200, not pc+4.
REQ-036 rst pulse mid-WAIT, stale mem_rsp_valid during IDLE -> ignored; first request 0x80000000.
REQ-037 With YSYX_22050612_IFU_EBREAK_HALT_EN, fetch 32'h00100073, consume -> halted=1, mem_req_valid 0 for 20 cycles; without macro -> next request at pc+4.

Source files
------------

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: a single-outstanding fetch FSM (IDLE/REQ/WAIT/HOLD/HALT).
// It issues one PC-addressed request, waits for the returned word, and holds it
// for the decoder. A redirect turns a fetch that is still in flight into a dropped
// fetch. Optional feature: define YSYX_22050612_IFU_EBREAK_HALT_EN so that a
// consumed ebreak parks the unit in HALT until reset.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halted
);

`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] drop_pc;
  logic        drop;

  // A request is withheld in any cycle that carries a redirect, because the PC is about to change.
  assign mem_req_valid = (state == REQ) && !redirect_valid;
  assign mem_req_addr  = pc;
  assign inst_valid    = (state == HOLD);

`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  // Fetch sequencing, PC update and capture of the returned instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop_pc <= RESET_PC;
      drop    <= 1'b0;
      inst    <= 32'd0;
      inst_pc <= 64'd0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              pc    <= redirect_valid ? redirect_pc : drop_pc;
              state <= REQ;
            end else begin
              inst    <= mem_rsp_data;
              inst_pc <= pc;
              state   <= HOLD;
            end
          end else if (redirect_valid) begin
            drop    <= 1'b1;
            drop_pc <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= REQ;
          end else if (inst_ready) begin
`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
            if (inst == EBREAK) begin
              state <= HALT;
            end else begin
              pc    <= pc + 64'd4;
              state <= REQ;
            end
`else
            pc    <= pc + 64'd4;
            state <= REQ;
`endif
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for ysyx_22050612_ifu: directed scenarios plus randomized fetch traffic.
// The expected fetch address stream is kept as a transaction-level PC model.
// Inputs change 1ns after the rising edge; outputs are read 1ns later.
module tb_ysyx_22050612_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        halted;

  int          total = 0;
  int          bad = 0;
  int          cyc_count = 0;
  int          accept_cycle = 0;
  logic [63:0] model_pc;
  logic [63:0] last_addr;
  logic [31:0] last_data;

  ysyx_22050612_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] rand_target();
    return {32'd0, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    d = $urandom;
    if (d == 32'h0010_0073) d = 32'h0000_0013;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the request, check its address against the model, accept after 'stall' offered cycles.
  task automatic issue(input int stall);
    int seen = 0;
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (mem_req_valid) begin
        total++;
        if (mem_req_addr !== model_pc) begin
          bad++;
          $display("[TB] FAIL req_addr: got %h want %h", mem_req_addr, model_pc);
        end
        if (seen >= stall) begin
          mem_req_ready = 1'b1;
          ok = 1;
          accept_cycle = cyc_count;
        end
        seen++;
      end
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
    end
    last_addr = model_pc;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL req_timeout: got 0 want 1");
    end
  endtask

  // Return a word after 'lat' cycles; mode 1: redirect(s) while waiting, 2: redirect with the
  // response, 3: redirect while waiting then again with the response (newest target wins).
  task automatic respond(input int lat, input logic [31:0] data, input int mode,
                         input logic [63:0] t1, input logic [63:0] t2, output bit dropped);
    logic [63:0] tgt;
    dropped = 0;
    tgt = model_pc;
    if (lat == 0 && mode == 1) mode = 0;
    if (lat == 0 && mode == 3) mode = 2;
    for (int k = 0; k < lat; k++) begin
      if ((mode == 1 || mode == 3) && k == 0) begin
        redirect_valid = 1'b1; redirect_pc = t1; dropped = 1; tgt = t1;
      end else if (mode == 1 && k == lat - 1) begin
        redirect_valid = 1'b1; redirect_pc = t2; tgt = t2;
      end
      #1;
      total++;
      if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL wait_quiet: got v=%0b req=%0b want v=0 req=0", inst_valid, mem_req_valid);
      end
      tick();
      redirect_valid = 1'b0;
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    if (mode == 2) begin redirect_valid = 1'b1; redirect_pc = t1; dropped = 1; tgt = t1; end
    if (mode == 3) begin redirect_valid = 1'b1; redirect_pc = t2; dropped = 1; tgt = t2; end
    tick();
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    total++;
    if (dropped) begin
      model_pc = tgt;
      if (inst_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL drop_valid: got %0b want 0", inst_valid);
      end
    end else begin
      last_data = data;
      if (inst_valid !== 1'b1 || inst !== data || inst_pc !== last_addr) begin
        bad++;
        $display("[TB] FAIL capture: got v=%0b inst=%h pc=%h want v=1 inst=%h pc=%h",
                 inst_valid, inst, inst_pc, data, last_addr);
      end
    end
  endtask

  // Hold the instruction for 'stall' cycles, then mode 0: consume, 1: redirect with ready, 2: redirect alone.
  task automatic hold(input int stall, input int mode, input logic [63:0] t);
    for (int k = 0; k < stall; k++) begin
      inst_ready    = 1'b0;
      mem_rsp_valid = 1'($urandom_range(1));
      mem_rsp_data  = $urandom;
      #1;
      total++;
      if (inst_valid !== 1'b1 || inst !== last_data || inst_pc !== last_addr || mem_req_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_stable: got v=%0b inst=%h pc=%h req=%0b want v=1 inst=%h pc=%h req=0",
                 inst_valid, inst, inst_pc, mem_req_valid, last_data, last_addr);
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
    inst_ready    = (mode != 2);
    if (mode != 0) begin redirect_valid = 1'b1; redirect_pc = t; end
    #1;
    total++;
    if (inst_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_valid: got %0b want 1", inst_valid);
    end
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_release: got %0b want 0", inst_valid);
    end
    model_pc = (mode == 0) ? model_pc + 64'd4 : t;
  endtask

  task automatic redirect_in_req(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    mem_req_ready  = 1'b1;
    #1;
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL req_redirect: got %0b want 0", mem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    model_pc = t;
  endtask

  task automatic fetch_plain(input logic [31:0] data);
    bit d;
    issue(0);
    respond(0, data, 0, 64'd0, 64'd0, d);
    hold(0, 0, 64'd0);
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0 ||
        halted !== 1'b0 || mem_req_addr !== RESET_PC) begin
      bad++;
      $display("[TB] FAIL reset_values: got req=%0b v=%0b inst=%h pc=%h h=%0b addr=%h want 0 0 0 0 0 %h",
               mem_req_valid, inst_valid, inst, inst_pc, halted, mem_req_addr, RESET_PC);
    end
    rst = 1'b0;
    model_pc = RESET_PC;
    #1;
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_quiet: got %0b want 0", mem_req_valid);
    end
    tick();
  endtask

  task automatic test_first_fetch();
    fetch_plain(32'h0000_0013);
    fetch_plain(32'h0010_0093);
  endtask

  task automatic test_hold_stall();
    bit d;
    issue(0);
    respond(1, 32'h0020_0113, 0, 64'd0, 64'd0, d);
    hold(5, 0, 64'd0);
    fetch_plain(32'h0030_0193);
  endtask

  task automatic test_wait_redirect();
    bit d;
    issue(0);
    respond(1, 32'hDEAD_BEEF, 1, 64'h8000_0100, 64'h8000_0100, d);
    fetch_plain(32'h0040_0213);
    issue(1);
    respond(3, 32'hDEAD_BEEF, 1, 64'h8000_0300, 64'h8000_0400, d);
    fetch_plain(32'h0050_0293);
    issue(0);
    respond(2, 32'hCAFE_F00D, 3, 64'h8000_0500, 64'h8000_0600, d);
    fetch_plain(32'h0060_0313);
  endtask

  task automatic test_hold_redirect();
    bit d;
    issue(0);
    respond(0, 32'h0070_0393, 0, 64'd0, 64'd0, d);
    hold(1, 1, 64'h8000_0200);
    fetch_plain(32'h0080_0413);
    issue(0);
    respond(0, 32'h0090_0493, 0, 64'd0, 64'd0, d);
    hold(0, 2, 64'h8000_0280);
    fetch_plain(32'h00A0_0513);
  endtask

  task automatic test_back_to_back();
    int prev;
    issue(0);
    prev = accept_cycle;
    for (int i = 0; i < 4; i++) begin
      bit d;
      respond(0, rand_data(), 0, 64'd0, 64'd0, d);
      hold(0, 0, 64'd0);
      issue(0);
      total++;
      if (accept_cycle - prev !== 3) begin
        bad++;
        $display("[TB] FAIL throughput: got %0d want 3", accept_cycle - prev);
      end
      prev = accept_cycle;
    end
    begin
      bit d;
      respond(0, 32'h00B0_0593, 0, 64'd0, 64'd0, d);
      hold(0, 0, 64'd0);
    end
  endtask

  task automatic test_wrap();
    redirect_in_req(64'hFFFF_FFFF_FFFF_FFFC);
    fetch_plain(32'h00C0_0613);
    total++;
    if (model_pc !== 64'd0) begin
      bad++;
      $display("[TB] FAIL wrap_model: got %h want 0", model_pc);
    end
    fetch_plain(32'h00D0_0693);
    redirect_in_req(64'h8000_1000);
  endtask

  task automatic test_reset_mid_wait();
    issue(0);
    rst           = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    #1;
    total++;
    if (inst !== 32'd0 || inst_pc !== 64'd0 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        halted !== 1'b0 || mem_req_addr !== RESET_PC) begin
      bad++;
      $display("[TB] FAIL async_reset: got inst=%h pc=%h v=%0b req=%0b h=%0b addr=%h want 0 0 0 0 0 %h",
               inst, inst_pc, inst_valid, mem_req_valid, halted, mem_req_addr, RESET_PC);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_stale: got v=%0b req=%0b want 0 0", inst_valid, mem_req_valid);
    end
    tick();
    mem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stale_ignored: got %0b want 0", inst_valid);
    end
    model_pc = RESET_PC;
    fetch_plain(32'h00E0_0713);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit d;
      int mode;
      int hmode;
      if ($urandom_range(3) == 0) redirect_in_req(rand_target());
      issue($urandom_range(2));
      mode = $urandom_range(5);
      if (mode > 3) mode = 0;
      respond($urandom_range(3), rand_data(), mode, rand_target(), rand_target(), d);
      if (!d) begin
        hmode = $urandom_range(5);
        if (hmode > 2) hmode = 0;
        hold($urandom_range(3), hmode, rand_target());
      end
    end
  endtask

  task automatic test_ebreak();
    bit d;
    issue(0);
    respond(0, 32'h0010_0073, 0, 64'd0, 64'd0, d);
`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
    inst_ready = 1'b1;
    tick();
    inst_ready    = 1'b0;
    mem_req_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      total++;
      if (halted !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL halt_state: got h=%0b req=%0b v=%0b want 1 0 0", halted, mem_req_valid, inst_valid);
      end
      tick();
    end
    mem_req_ready = 1'b0;
`else
    hold(0, 0, 64'd0);
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL halted_tied: got %0b want 0", halted);
    end
    fetch_plain(32'h00F0_0793);
`endif
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_wait_redirect();
    test_hold_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    test_ebreak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
